tone_decoder: RTL
=================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter LOCK_N, default 3: consecutive matching periods required to lock or change note.
REQ-002 Parameter TIMEOUT, default 250_000: number of cycles without a rising edge before silence is declared.
REQ-003 Parameter TOL_SHIFT, default 6: tolerance window is nominal >> TOL_SHIFT, giving about ±1.56%.
REQ-004 sys_clk  input  1  50 MHz system clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 tone_in  input  1  asynchronous square wave of any duty cycle, for example a buzzer PWM tapped back or a comparator output.
REQ-007 note  output  3  0 = none, 1..7 = DO, RE, MI, FA, SO, LA, XI.
REQ-008 note_valid  output  1  high while a note is locked.
REQ-009 note_change  output  1  one-cycle pulse when note takes a new nonzero value.
REQ-010 period  output  18  last measured rising-edge-to-rising-edge period, in cycles.
REQ-011 led  output  4  {note_valid, note[2:0]}; 1 = lit.

Function
REQ-012 tone_in SHALL pass a 2-FF synchronizer plus one edge register; rise = sync2 & ~sync3; latency from tone_in edge to rise is 3 cycles.
REQ-013 Period counter cnt[17:0] SHALL increment every cycle and saturate at 262_143.
- On rise: period <= cnt + 1 and cnt <= 0.
REQ-014 Nominal periods in cycles are DO 190_840, RE 170_068, MI 151_515, FA 143_266, SO 127_551, LA 113_636, XI 101_215.
- Classification SHALL return code k when |P - nominal_k| <= nominal_k >> TOL_SHIFT, else 0.
- Windows are disjoint at the default TOL_SHIFT.
REQ-015 FSM states SHALL be SILENT, ARMED and LOCKED; reset state is SILENT.
REQ-016 SILENT: on rise, go to ARMED, clear cnt and clear the match counter; measured period is discarded.
REQ-017 ARMED, on rise with nonzero class:
- class equals candidate: match_cnt increments.
- otherwise: candidate <= class and match_cnt <= 1.
REQ-018 ARMED, on rise with class 0: match_cnt <= 0.
REQ-019 ARMED lock: when match_cnt reaches LOCK_N, go to LOCKED on the same update.
- note <= candidate, note_valid <= 1, note_change pulses for one cycle.
REQ-020 LOCKED, class equals note: mismatch tracking clears.
REQ-021 LOCKED, class differs from note: track that class as a candidate, using the same counting rule as ARMED.
- At LOCK_N consecutive identical nonzero classes: note switches and note_change pulses; note_valid stays 1.
- At LOCK_N consecutive class-0 periods: go to ARMED, note <= 0, note_valid <= 0, no pulse.
REQ-022 In ARMED or LOCKED, when cnt reaches TIMEOUT with no rise in that cycle:
- go to SILENT; note <= 0, note_valid <= 0, match_cnt <= 0.
- If rise and timeout coincide, rise wins.
REQ-023 All outputs SHALL be registered; note_valid and note_change are asserted the cycle after the deciding rise.
REQ-024 Only rising edges are used; duty cycle SHALL NOT affect the result.

Reset
REQ-025 rst_n low SHALL immediately force the following, including mid-lock:
- note = 0, note_valid = 0, note_change = 0, period = 0, led = 0.
- cnt = 0, match_cnt = 0, candidate = 0, synchronizer flops = 0, state SILENT.
REQ-026 After release, a new lock SHALL require a fresh sequence of LOCK_N + 1 rising edges.

Structure
REQ-027 Package tone_pkg SHALL hold:
- the seven nominal period constants;
- the note code constants (NONE, DO..XI);
- the FSM state encoding;
- the tone generator SHALL import the same package, so its overflow values become nominal - 1.
REQ-028 Sub-module tone_classify SHALL be a purely combinational period[17:0] to code[2:0] mapper parameterised by TOL_SHIFT; the FSM, counter and synchronizer stay in tone_decoder.

Verification
REQ-029 Lock: 10%-duty wave, period 190_840.
- After the 4th rise: note=1, note_valid=1, led=4'b1001.
- Exactly one note_change pulse.
REQ-030 Note switch: while locked on DO, switch the period to 101_215.
- note holds 1 for the first two XI periods.
- After the third XI period: note=7, one note_change pulse, led=4'b1111.
REQ-031 Timeout: stop toggling while locked.
- note_valid stays high through 249_999 cycles after the last rise.
- At 250_000: note=0, note_valid=0, led=0.
REQ-032 Out of band: period 160_000.
- period output reads 160_000.
- note_valid never asserts.
REQ-033 Tolerance edge (DO):
- Period 193_821 (nominal + 2981): locks.
- Period 193_822 (nominal + 2982): never locks.
REQ-034 Reset mid-lock: pulse rst_n low while LOCKED.
- Outputs go to 0 asynchronously.
- Relock after release needs 4 rises.
- A rise coinciding with cnt==TIMEOUT keeps LOCKED.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants for the tone decoder: nominal note periods,
// note codes and FSM state encoding.
package tone_pkg;

    localparam logic [17:0] NOM_DO = 18'd190840;
    localparam logic [17:0] NOM_RE = 18'd170068;
    localparam logic [17:0] NOM_MI = 18'd151515;
    localparam logic [17:0] NOM_FA = 18'd143266;
    localparam logic [17:0] NOM_SO = 18'd127551;
    localparam logic [17:0] NOM_LA = 18'd113636;
    localparam logic [17:0] NOM_XI = 18'd101215;

    localparam logic [2:0] NOTE_NONE = 3'd0;
    localparam logic [2:0] NOTE_DO   = 3'd1;
    localparam logic [2:0] NOTE_RE   = 3'd2;
    localparam logic [2:0] NOTE_MI   = 3'd3;
    localparam logic [2:0] NOTE_FA   = 3'd4;
    localparam logic [2:0] NOTE_SO   = 3'd5;
    localparam logic [2:0] NOTE_LA   = 3'd6;
    localparam logic [2:0] NOTE_XI   = 3'd7;

    localparam logic [17:0] CNT_MAX = 18'h3FFFF;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [17:0] nominal(input logic [2:0] code);
        logic [17:0] n;
        case (code)
            NOTE_DO: n = NOM_DO;
            NOTE_RE: n = NOM_RE;
            NOTE_MI: n = NOM_MI;
            NOTE_FA: n = NOM_FA;
            NOTE_SO: n = NOM_SO;
            NOTE_LA: n = NOM_LA;
            NOTE_XI: n = NOM_XI;
            default: n = 18'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tone_classify.sv
// Combinational period-to-note mapper; a period within
// nominal >> TOL_SHIFT of a nominal yields that note code.
module tone_classify
    import tone_pkg::*;
#(
    parameter int TOL_SHIFT = 6
) (
    input  logic [17:0] period,
    output logic [2:0]  code
);

    function automatic logic in_window(
        input logic [17:0] p,
        input logic [17:0] nom
    );
        logic [17:0] diff;
        diff = (p >= nom) ? p - nom : nom - p;
        return diff <= (nom >> TOL_SHIFT);
    endfunction

    // Scan all seven notes; windows are disjoint so at most one hits.
    always_comb begin
        code = NOTE_NONE;
        for (int k = 1; k < 8; k++) begin
            if (in_window(period, nominal(3'(k))))
                code = 3'(k);
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// Square-wave note decoder: measures rise-to-rise period, classifies
// it and locks onto a note after LOCK_N consecutive agreeing periods.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int LOCK_N    = 3,
    parameter int TIMEOUT   = 250_000,
    parameter int TOL_SHIFT = 6
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic [2:0]  note,
    output logic        note_valid,
    output logic        note_change,
    output logic [17:0] period,
    output logic [3:0]  led
);

    localparam int MW = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_N);
    localparam logic [17:0] TIMEOUT_C = 18'(TIMEOUT);

    logic [2:0]    sync;
    logic [17:0]   cnt;
    logic [17:0]   meas;
    logic [2:0]    cls;
    logic          rise;
    logic          timeout;

    state_t        state, state_n;
    logic [2:0]    cand, cand_n;
    logic [MW-1:0] mc, mc_n;
    logic [2:0]    note_n;
    logic          valid_n;
    logic          chg_n;

    assign rise    = sync[1] & ~sync[2];
    assign meas    = (cnt == CNT_MAX) ? CNT_MAX : cnt + 18'd1;
    assign timeout = (cnt == TIMEOUT_C) && !rise;
    assign led     = {note_valid, note};

    tone_classify #(
        .TOL_SHIFT(TOL_SHIFT)
    ) u_classify (
        .period(meas),
        .code  (cls)
    );

    // Synchronizer, edge register and saturating period counter.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            cnt    <= '0;
            period <= '0;
        end else begin
            sync <= {sync[1:0], tone_in};
            if (rise) begin
                cnt    <= '0;
                period <= meas;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 18'd1;
            end
        end
    end

    // FSM and output registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SILENT;
            cand        <= NOTE_NONE;
            mc          <= '0;
            note        <= NOTE_NONE;
            note_valid  <= 1'b0;
            note_change <= 1'b0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            mc          <= mc_n;
            note        <= note_n;
            note_valid  <= valid_n;
            note_change <= chg_n;
        end
    end

    // Next-state: count agreeing periods, lock, switch or drop out.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        mc_n    = mc;
        note_n  = note;
        valid_n = note_valid;
        chg_n   = 1'b0;
        case (state)
            SILENT: begin
                if (rise) begin
                    state_n = ARMED;
                    mc_n    = '0;
                    cand_n  = NOTE_NONE;
                end
            end
            ARMED: begin
                if (rise) begin
                    if (cls == NOTE_NONE) begin
                        mc_n = '0;
                    end else begin
                        if (cls == cand) begin
                            mc_n = mc + MW'(1);
                        end else begin
                            cand_n = cls;
                            mc_n   = MW'(1);
                        end
                        if (mc_n == LOCK_M) begin
                            state_n = LOCKED;
                            note_n  = cand_n;
                            valid_n = 1'b1;
                            chg_n   = 1'b1;
                            mc_n    = '0;
                            cand_n  = NOTE_NONE;
                        end
                    end
                end else if (timeout) begin
                    state_n = SILENT;
                    note_n  = NOTE_NONE;
                    valid_n = 1'b0;
                    mc_n    = '0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (cls == note) begin
                        mc_n   = '0;
                        cand_n = NOTE_NONE;
                    end else begin
                        if (cls == cand && mc != '0) begin
                            mc_n = mc + MW'(1);
                        end else begin
                            cand_n = cls;
                            mc_n   = MW'(1);
                        end
                        if (mc_n == LOCK_M) begin
                            mc_n   = '0;
                            cand_n = NOTE_NONE;
                            if (cls == NOTE_NONE) begin
                                state_n = ARMED;
                                note_n  = NOTE_NONE;
                                valid_n = 1'b0;
                            end else begin
                                note_n = cls;
                                chg_n  = 1'b1;
                            end
                        end
                    end
                end else if (timeout) begin
                    state_n = SILENT;
                    note_n  = NOTE_NONE;
                    valid_n = 1'b0;
                    mc_n    = '0;
                end
            end
            default: begin
                state_n = SILENT;
            end
        endcase
    end

endmodule
